// File: rtl/voice_record_ctrl_pkg.sv
// Shared definitions for the voice record controller and the game FSM.
// State encoding, default buffer geometry and the mic-detect threshold.
package voice_record_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_RECORD = 2'd2,
      ST_DONE   = 2'd3
   } rec_state_t;

   localparam int VR_DEPTH         = 16;
   localparam int VR_VOL_W         = 5;
   localparam int VR_MIN_THRESHOLD = 3;

endpackage

// File: rtl/voice_record_ctrl_sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// Reusable wherever a slow periodic strobe is needed (sampling, countdowns).
module voice_record_ctrl_sample_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;

   // Divider counter: synchronous clear wins over counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = en && (cnt_r == LAST);

endmodule

// File: rtl/voice_record_ctrl.sv
// Voice capture sequencer: samples gated mic volume into a small buffer while the
// record button is held. Build option RECORD_PEAK_HOLD_EN stores the per-tick peak.
module voice_record_ctrl
   import voice_record_ctrl_pkg::*;
#(
   parameter int DEPTH         = VR_DEPTH,
   parameter int VOL_W         = VR_VOL_W,
   parameter int TICK_DIV      = 2500000,
   parameter int MIN_THRESHOLD = VR_MIN_THRESHOLD,
   parameter int MIN_SAMPLES   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arm,
   input  logic                     rec_btn,
   input  logic [VOL_W-1:0]         volume,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [VOL_W-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     valid,
   output logic                     done,
   output logic                     too_short
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   rec_state_t       state_r, state_nx_s;
   logic             btn_s1_r, btn_s2_r, btn_prev_r;
   logic             rise_s, fall_s, tick_s;
   logic             wr_s, clear_s, short_s;
   logic [CNT_W-1:0] count_r, cnt_inc_s;
   logic [VOL_W-1:0] mem_r [DEPTH];
   logic [VOL_W-1:0] cand_s, gated_s, rd_data_r;
   logic             busy_r, valid_r, done_r, too_short_r;

   // Button synchroniser plus previous-value flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1_r   <= 1'b0;
         btn_s2_r   <= 1'b0;
         btn_prev_r <= 1'b0;
      end else begin
         btn_s1_r   <= rec_btn;
         btn_s2_r   <= btn_s1_r;
         btn_prev_r <= btn_s2_r;
      end
   end

   assign rise_s = btn_s2_r & ~btn_prev_r;
   assign fall_s = ~btn_s2_r & btn_prev_r;

   voice_record_ctrl_sample_tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_r == ST_RECORD),
      .clr   (state_r != ST_RECORD),
      .tick  (tick_s)
   );

`ifdef RECORD_PEAK_HOLD_EN
   logic [VOL_W-1:0] peak_r;

   // Peak of the volume over the current tick interval; restarts after each tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_r <= {VOL_W{1'b0}};
      end else if ((state_r != ST_RECORD) || tick_s) begin
         peak_r <= {VOL_W{1'b0}};
      end else begin
         peak_r <= cand_s;
      end
   end

   assign cand_s = (volume > peak_r) ? volume : peak_r;
`else
   assign cand_s = volume;
`endif

   assign gated_s = (cand_s > VOL_W'(MIN_THRESHOLD)) ? cand_s : {VOL_W{1'b0}};

   // Next-state logic; arm overrides every other event, including a pending tick.
   always_comb begin
      state_nx_s = state_r;
      wr_s       = 1'b0;
      clear_s    = 1'b0;
      short_s    = 1'b0;
      cnt_inc_s  = count_r;
      if (arm) begin
         state_nx_s = ST_ARMED;
         clear_s    = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nx_s = ST_IDLE;
            end
            ST_ARMED: begin
               if (rise_s) begin
                  state_nx_s = ST_RECORD;
               end else begin
                  state_nx_s = ST_ARMED;
               end
            end
            ST_RECORD: begin
               if (tick_s) begin
                  wr_s      = 1'b1;
                  cnt_inc_s = count_r + CNT_W'(1);
               end else begin
                  cnt_inc_s = count_r;
               end
               // The length check sees the sample written in the same cycle.
               if (tick_s && (cnt_inc_s == CNT_W'(DEPTH))) begin
                  state_nx_s = ST_DONE;
               end else if (fall_s) begin
                  if (cnt_inc_s >= CNT_W'(MIN_SAMPLES)) begin
                     state_nx_s = ST_DONE;
                  end else begin
                     state_nx_s = ST_ARMED;
                     short_s    = 1'b1;
                     clear_s    = 1'b1;
                  end
               end else begin
                  state_nx_s = ST_RECORD;
               end
            end
            ST_DONE: begin
               state_nx_s = ST_DONE;
            end
            default: begin
               state_nx_s = ST_IDLE;
            end
         endcase
      end
   end

   // State register and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         valid_r     <= 1'b0;
         done_r      <= 1'b0;
         too_short_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         busy_r      <= (state_nx_s == ST_ARMED) || (state_nx_s == ST_RECORD);
         valid_r     <= (state_nx_s == ST_DONE);
         done_r      <= (state_nx_s == ST_DONE) && (state_r != ST_DONE);
         too_short_r <= short_s;
      end
   end

   // Sample buffer and write pointer; clearing wipes every entry at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {VOL_W{1'b0}};
      end else if (clear_s) begin
         count_r <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {VOL_W{1'b0}};
      end else if (wr_s) begin
         mem_r[count_r[IDX_W-1:0]] <= gated_s;
         count_r                   <= cnt_inc_s;
      end else begin
         count_r <= count_r;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r <= {VOL_W{1'b0}};
      end else begin
         rd_data_r <= mem_r[rd_idx];
      end
   end

   assign rd_data   = rd_data_r;
   assign count     = count_r;
   assign busy      = busy_r;
   assign valid     = valid_r;
   assign done      = done_r;
   assign too_short = too_short_r;

endmodule

// File: tb/tb_voice_record_ctrl.sv
// Self-checking bench for voice_record_ctrl with TICK_DIV=4 and random volumes.
module tb_voice_record_ctrl;

   localparam int DEPTH  = 16;
   localparam int VOL_W  = 5;
   localparam int DIV    = 4;
   localparam int MIN_TH = 3;
   localparam int MIN_S  = 4;

   logic             clk = 1'b0;
   logic             rst_n, arm, rec_btn;
   logic [VOL_W-1:0] volume;
   logic [3:0]       rd_idx;
   logic [VOL_W-1:0] rd_data;
   logic [4:0]       count;
   logic             busy, valid, done, too_short;

   int pass_cnt  = 0;
   int total_cnt = 0;

   voice_record_ctrl #(
      .DEPTH(DEPTH), .VOL_W(VOL_W), .TICK_DIV(DIV),
      .MIN_THRESHOLD(MIN_TH), .MIN_SAMPLES(MIN_S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .rec_btn(rec_btn), .volume(volume),
      .rd_idx(rd_idx), .rd_data(rd_data), .count(count), .busy(busy),
      .valid(valid), .done(done), .too_short(too_short)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] gate(input logic [4:0] v);
      return (v > 5'(MIN_TH)) ? v : 5'd0;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Arm, then press the button: RECORD is entered on the third edge after the press.
   task automatic start_rec(input logic [4:0] v0);
      rec_btn = 1'b0;
      step(3);
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      volume  = v0;
      rec_btn = 1'b1;
      step(3);
   endtask

   task automatic test_reset();
      start_rec(5'd10);
      for (int k = 1; k <= 5; k++) step(DIV);
      step(2);
      total_cnt++;
      if (count !== 5'd5) $display("FAIL reset_precount: got %0d expected 5", count);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({count, busy, valid, done, too_short, rd_data} !== 14'd0)
         $display("FAIL reset_async_outputs: got cnt=%0d busy=%0b valid=%0b done=%0b short=%0b rd=%0d expected all 0",
                  count, busy, valid, done, too_short, rd_data);
      else pass_cnt++;
      rec_btn = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(3);
      total_cnt++;
      if ({busy, valid, count} !== 7'd0)
         $display("FAIL reset_idle: got busy=%0b valid=%0b cnt=%0d expected 0", busy, valid, count);
      else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = 4'(i);
         step(1);
         total_cnt++;
         if (rd_data !== 5'd0) $display("FAIL reset_rd[%0d]: got %0d expected 0", i, rd_data);
         else pass_cnt++;
      end
   endtask

   // Record n samples with the given volumes, release, then check the whole buffer.
   task automatic record_and_check(input int n, input logic [4:0] vols [DEPTH], input string tag);
      int dones, shorts;
      logic [4:0] exp;
      start_rec(vols[0]);
      for (int k = 1; k <= n; k++) begin
         step(DIV);
         total_cnt++;
         if (count !== 5'(k) || done !== 1'b0)
            $display("FAIL %s_count_k%0d: got cnt=%0d done=%0b expected cnt=%0d done=0", tag, k, count, done, k);
         else pass_cnt++;
         if (k < n) volume = vols[k];
      end
      rec_btn = 1'b0;
      dones = 0;
      shorts = 0;
      for (int c = 0; c < 6; c++) begin
         step(1);
         dones += int'(done);
         shorts += int'(too_short);
      end
      total_cnt++;
      if (dones != 1 || shorts != 0 || valid !== 1'b1 || busy !== 1'b0 || count !== 5'(n))
         $display("FAIL %s_accept: got done_pulses=%0d short_pulses=%0d valid=%0b busy=%0b cnt=%0d expected 1 0 1 0 %0d",
                  tag, dones, shorts, valid, busy, count, n);
      else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = 4'(i);
         step(1);
         exp = (i < n) ? gate(vols[i]) : 5'd0;
         total_cnt++;
         if (rd_data !== exp) $display("FAIL %s_rd[%0d]: got %0d expected %0d", tag, i, rd_data, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_normal();
      logic [4:0] vols [DEPTH];
      for (int i = 0; i < DEPTH; i++) vols[i] = 5'd9;
      record_and_check(6, vols, "normal");
   endtask

   task automatic test_random();
      logic [4:0] vols [DEPTH];
      int n;
      for (int it = 0; it < 4; it++) begin
         n = int'($urandom_range(MIN_S, DEPTH - 1));
         for (int i = 0; i < DEPTH; i++) vols[i] = 5'($urandom_range(0, 31));
         record_and_check(n, vols, "random");
      end
   endtask

   task automatic test_too_short();
      int dones, shorts;
      start_rec(5'd3);
      step(2 * DIV);
      total_cnt++;
      if (count !== 5'd2) $display("FAIL short_precount: got %0d expected 2", count);
      else pass_cnt++;
      rec_btn = 1'b0;
      dones = 0;
      shorts = 0;
      for (int c = 0; c < 6; c++) begin
         step(1);
         dones += int'(done);
         shorts += int'(too_short);
      end
      total_cnt++;
      if (shorts != 1 || dones != 0 || busy !== 1'b1 || valid !== 1'b0 || count !== 5'd0)
         $display("FAIL short_reject: got short_pulses=%0d done_pulses=%0d busy=%0b valid=%0b cnt=%0d expected 1 0 1 0 0",
                  shorts, dones, busy, valid, count);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         rd_idx = 4'(i);
         step(1);
         total_cnt++;
         if (rd_data !== 5'd0) $display("FAIL short_rd[%0d]: got %0d expected 0", i, rd_data);
         else pass_cnt++;
      end
   endtask

   task automatic test_full();
      int pulses;
      start_rec(5'd20);
      for (int k = 1; k <= DEPTH; k++) begin
         step(DIV);
         total_cnt++;
         if (count !== 5'(k) || done !== (k == DEPTH))
            $display("FAIL full_k%0d: got cnt=%0d done=%0b expected cnt=%0d done=%0b", k, count, done, k, k == DEPTH);
         else pass_cnt++;
      end
      step(2);
      rec_btn = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         step(1);
         pulses += int'(done) + int'(too_short);
      end
      total_cnt++;
      if (pulses != 0 || valid !== 1'b1 || count !== 5'd16)
         $display("FAIL full_release: got pulses=%0d valid=%0b cnt=%0d expected 0 1 16", pulses, valid, count);
      else pass_cnt++;
      rd_idx = 4'd15;
      step(1);
      total_cnt++;
      if (rd_data !== 5'd20) $display("FAIL full_rd15: got %0d expected 20", rd_data);
      else pass_cnt++;
   endtask

   // Release timed so the fall acts on the same edge as the fourth tick.
   task automatic test_simul();
      logic [4:0] v;
      v = 5'($urandom_range(0, 31));
      start_rec(v);
      step(3 * DIV);
      step(1);
      rec_btn = 1'b0;
      step(DIV - 1);
      total_cnt++;
      if (count !== 5'd4 || done !== 1'b1 || too_short !== 1'b0 || valid !== 1'b1)
         $display("FAIL simul_accept: got cnt=%0d done=%0b short=%0b valid=%0b expected 4 1 0 1",
                  count, done, too_short, valid);
      else pass_cnt++;
      rd_idx = 4'd3;
      step(1);
      total_cnt++;
      if (rd_data !== gate(v)) $display("FAIL simul_rd3: got %0d expected %0d", rd_data, gate(v));
      else pass_cnt++;
   endtask

   task automatic test_abort();
      start_rec(5'd12);
      step(7 * DIV);
      total_cnt++;
      if (count !== 5'd7) $display("FAIL abort_precount: got %0d expected 7", count);
      else pass_cnt++;
      step(DIV - 1);
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      total_cnt++;
      if (count !== 5'd0 || busy !== 1'b1 || valid !== 1'b0 || done !== 1'b0 || too_short !== 1'b0)
         $display("FAIL abort_state: got cnt=%0d busy=%0b valid=%0b done=%0b short=%0b expected 0 1 0 0 0",
                  count, busy, valid, done, too_short);
      else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) begin
         rd_idx = 4'(i);
         step(1);
         total_cnt++;
         if (rd_data !== 5'd0) $display("FAIL abort_rd[%0d]: got %0d expected 0", i, rd_data);
         else pass_cnt++;
      end
      total_cnt++;
      if (count !== 5'd0 || busy !== 1'b1) $display("FAIL abort_hold: got cnt=%0d busy=%0b expected 0 1", count, busy);
      else pass_cnt++;
   endtask

   initial begin
      rst_n   = 1'b0;
      arm     = 1'b0;
      rec_btn = 1'b0;
      volume  = 5'd0;
      rd_idx  = 4'd0;
      step(3);
      rst_n = 1'b1;
      step(2);
      test_reset();
      test_normal();
      test_too_short();
      test_random();
      test_full();
      test_simul();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
